alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational 32-bit ALU between two requesters (e.g. the execute stage and the branch/address unit). Each requester issues an operation through a valid/ready request channel. The arbiter grants one requester, registers its operands onto the ALU inputs, captures the result one cycle later, and returns it on that requester's valid/ready response channel. The ALU itself stays purely combinational; this block owns all sequencing and arbitration.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width; must match the ALU.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i is requester i.
- `req_ready`  out  2  per-requester accept; one-hot or zero.
- `req_op0`, `req_op1`  in  3  ALUcontrol code per requester, forwarded unchanged.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  WIDTH  operands.
- `rsp_valid`  out  2  per-requester result valid; one-hot or zero.
- `rsp_ready`  in  2  per-requester result accept.
- `rsp_data`  out  WIDTH  result; shared by both requesters, qualified by `rsp_valid`.
- `rsp_zero`  out  1  captured ALU `zero` flag (a == b), shared.
- `alu_a`, `alu_b`  out  WIDTH  registered ALU operands.
- `alu_ctrl`  out  3  registered ALUcontrol.
- `alu_out`  in  WIDTH  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- IDLE:
  - If any `req_valid` bit is set, select requester g.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - On the clock edge, load `alu_a`/`alu_b`/`alu_ctrl` from requester g, record g, and go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC: capture `alu_out` into `rsp_data` and `alu_zero` into `rsp_zero`; go to RESP.
- RESP:
  - `rsp_valid[g]` = 1.
  - When `rsp_ready[g]` = 1, go to IDLE and update the priority pointer.
  - Otherwise hold; `rsp_data` and `rsp_zero` stay stable while waiting.
- `req_ready` is 0 in EXEC and RESP. There is no pipelining: one operation is in flight at a time.
- `alu_a`, `alu_b` and `alu_ctrl` hold their last values outside EXEC; there is no bubble zeroing.
- Arbitration is round-robin (see Configuration). The pointer points at the requester with priority. After a grant completes, the pointer moves to the other requester.
- `alu_ctrl` is forwarded as-is. The arbiter never decodes or validates opcodes.
- Reset in any state:
  - All outputs go to 0, state goes to IDLE, pointer goes to requester 0.
  - An in-flight operation is dropped and produces no response.

## Timing
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_zero` = 0, `alu_a` = 0, `alu_b` = 0, `alu_ctrl` = 0, `busy` = 0.
- Latency from the accept edge:
  - `alu_*` valid at cycle +1.
  - Result captured at the end of cycle +1.
  - `rsp_valid` high at cycle +2.
- Minimum spacing between accepts is 3 cycles when `rsp_ready` is held at 1.
- `req_ready` depends combinationally on `req_valid`, the state and the pointer only; it never depends on `rsp_ready`.
- The ALU path (`alu_a`/`alu_b` → `alu_out`) must close within one cycle.
- A new request arriving while the block is in RESP waits. It is granted in the IDLE cycle after the response handshake.
- Simultaneous requests in IDLE: exactly one grant, chosen by the pointer. The loser's `req_ready` stays 0, and it must hold valid and its operands.

## Configuration
- `ALU_ARB_RR_EN` defined:
  - Round-robin priority pointer as described in Operation.
- `ALU_ARB_RR_EN` undefined:
  - Fixed priority; requester 0 always wins simultaneous requests.
  - The pointer register is not built.
  - Requester 1 may starve.

## Test plan
- Reset mid-EXEC:
  - Stimulus: req0 op 010, a=5, b=7; deassert `rst_n` in EXEC.
  - Required: all outputs 0 immediately, no `rsp_valid`, next grant is normal.
- Single add:
  - Stimulus: `req_valid` = 01, op 010, a=5, b=7, `rsp_ready` = 1.
  - Required: `req_ready` = 01 in cycle 0; `alu_ctrl` = 010 in cycle 1; `rsp_valid` = 01, `rsp_data` = 12, `rsp_zero` = 0 in cycle 2.
- Zero flag:
  - Stimulus: req1 a = b = 0xDEADBEEF, op 110.
  - Required: `rsp_valid` = 10, `rsp_zero` = 1.
- Back-pressure:
  - Stimulus: req0 completes, `rsp_ready` held at 0 for 5 cycles.
  - Required: `rsp_valid` = 01 and `rsp_data` stable for all 5 cycles; `req_ready` = 00 throughout; `busy` = 1.
- Contention:
  - Stimulus: both requesters valid continuously, 4 ops each.
  - Required with the macro defined: grants alternate 0,1,0,1,…
  - Required with the macro undefined: all 4 of requester 0's grants come before any of requester 1's.
- Throughput:
  - Stimulus: 10 back-to-back req0 ops with `rsp_ready` = 1.
  - Required: exactly 30 cycles from the first accept to the last response handshake plus one.

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// ALU_ARB_RR_EN selects round-robin priority; otherwise requester 0 always wins.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_next;
  logic   grant;
  logic   sel;

`ifdef ALU_ARB_RR_EN
  logic ptr;

  // Priority passes to the other requester once a response handshake completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (state == RESP && rsp_ready[grant]) begin
      ptr <= ~grant;
    end
  end

  always_comb begin
    sel = (req_valid == 2'b11) ? ptr : req_valid[1];
  end
`else
  always_comb begin
    sel = req_valid[1] & ~req_valid[0];
  end
`endif

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    case (state)
      IDLE: begin
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready[sel] = 1'b1;
          state_next     = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid[grant] = 1'b1;
        if (rsp_ready[grant]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= 3'b000;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid != 2'b00) begin
        grant    <= sel;
        alu_a    <= sel ? req_a1 : req_a0;
        alu_b    <= sel ? req_b1 : req_b0;
        alu_ctrl <= sel ? req_op1 : req_op0;
      end
      // Result is held through RESP so back-pressure cannot disturb it
      if (state == EXEC) begin
        rsp_data <= alu_out;
        rsp_zero <= alu_zero;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, scoreboard monitor, and
// hand-written reset, back-pressure, contention and throughput sequences.
module tb_alu_arbiter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [2:0]       req_op0 = 3'b000, req_op1 = 3'b000;
  logic [WIDTH-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = 2'b11;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [2:0]       alu_ctrl;
  logic             alu_zero;
  logic             busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  who;
    logic [31:0] data;
    logic        zero;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic        who;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        zero;
  } vec_t;
  vec_t vecs[7];

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  alu_fn = a & b;
      3'b001:  alu_fn = a | b;
      3'b010:  alu_fn = a + b;
      3'b110:  alu_fn = a - b;
      3'b111:  alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_fn = 32'd0;
    endcase
  endfunction

  assign alu_out  = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_zero = (alu_a == alu_b);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_data"}, rsp_data, 0);
    checkOutput({tag, "_rsp_zero"}, rsp_zero, 0);
    checkOutput({tag, "_alu_a"}, alu_a, 0);
    checkOutput({tag, "_alu_b"}, alu_b, 0);
    checkOutput({tag, "_alu_ctrl"}, alu_ctrl, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic driveReq(input logic who, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (who) begin
      req_op1 = op; req_a1 = a; req_b1 = b;
    end else begin
      req_op0 = op; req_a0 = a; req_b0 = b;
    end
  endtask

  // Scoreboard: every response handshake pops and compares one expectation
  always @(negedge clk) begin
    #4;
    if (rst_n && (rsp_valid & rsp_ready) != 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rsp actual=%b required=00", rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_rsp_valid", rsp_valid, mon_e.who);
        checkOutput("sb_rsp_data", rsp_data, mon_e.data);
        checkOutput("sb_rsp_zero", rsp_zero, mon_e.zero);
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    logic [1:0] oh;
    oh = v.who ? 2'b10 : 2'b01;
    @(negedge clk);
    driveReq(~v.who, 3'($urandom_range(7)), $urandom, $urandom);
    driveReq(v.who, v.op, v.a, v.b);
    req_valid = oh;
    rsp_ready = 2'b11;
    sb.push_back('{oh, v.data, v.zero});
    #1 checkOutput("vec_req_ready_c0", req_ready, oh);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checkOutput("vec_alu_ctrl_c1", alu_ctrl, v.op);
    checkOutput("vec_alu_a_c1", alu_a, v.a);
    checkOutput("vec_alu_b_c1", alu_b, v.b);
    checkOutput("vec_busy_c1", busy, 1);
    checkOutput("vec_req_ready_c1", req_ready, 0);
    @(negedge clk);
    #1 checkOutput("vec_rsp_valid_c2", rsp_valid, oh);
    @(negedge clk);
    #1 checkOutput("vec_busy_idle", busy, 0);
  endtask

  initial begin
    int idx0, idx1, pushed, hs, first_acc, last_hs;
    int cnt[2];
    logic [1:0] gl[$];
    logic [1:0] exp_g[8];

    vecs[0] = '{1'b0, 3'b010, 32'd5, 32'd7, 32'd12, 1'b0};
    vecs[1] = '{1'b1, 3'b110, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 1'b1};
    vecs[2] = '{1'b0, 3'b000, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0};
    vecs[3] = '{1'b1, 3'b001, 32'h000000A0, 32'h0000000B, 32'h000000AB, 1'b0};
    vecs[4] = '{1'b0, 3'b111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0};
    vecs[5] = '{1'b1, 3'b010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
    vecs[6] = '{1'b0, 3'b110, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0};

    repeat (2) @(negedge clk);
    #1 checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Back-pressure, with requester 1 arriving while the response is stalled
    @(negedge clk);
    driveReq(1'b0, 3'b010, 32'd100, 32'd23);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    sb.push_back('{2'b01, 32'd123, 1'b0});
    @(negedge clk);
    req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        driveReq(1'b1, 3'b001, 32'd1, 32'd2);
        sb.push_back('{2'b10, 32'd3, 1'b0});
      end
      req_valid = 2'b10;
      #1;
      checkOutput("bp_rsp_valid", rsp_valid, 2'b01);
      checkOutput("bp_rsp_data", rsp_data, 123);
      checkOutput("bp_req_ready", req_ready, 0);
      checkOutput("bp_busy", busy, 1);
    end
    @(negedge clk);
    rsp_ready = 2'b11;
    #1 checkOutput("bp_req_ready_hs", req_ready, 0);
    @(negedge clk);
    #1 checkOutput("bp_req_ready_after", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Reset mid-EXEC drops the operation
    driveReq(1'b0, 3'b010, 32'd5, 32'd7);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    #1 checkOutput("rst_exec_alu_ctrl", alu_ctrl, 3'b010);
    rst_n = 1'b0;
    #1 checkResetOutputs("rst_exec");
    @(negedge clk);
    #1 checkResetOutputs("rst_exec_hold");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(vecs[0]);

    // Contention from a fresh reset so the pointer starts at requester 0
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef ALU_ARB_RR_EN
    exp_g = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_g = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
`endif
    cnt[0] = 0;
    cnt[1] = 0;
    for (int k = 0; k < 8; k++) begin
      if (exp_g[k] == 2'd1) begin
        sb.push_back('{2'b10, 32'(100 * (cnt[1] + 1) - 1), 1'b0});
        cnt[1]++;
      end else begin
        sb.push_back('{2'b01, 32'(cnt[0] + 11), 1'b0});
        cnt[0]++;
      end
    end
    idx0 = 0;
    idx1 = 0;
    rsp_ready = 2'b11;
    for (int t = 0; t < 200 && !(idx0 == 4 && idx1 == 4 && sb.size() == 0); t++) begin
      @(negedge clk);
      req_valid = {idx1 < 4, idx0 < 4};
      driveReq(1'b0, 3'b010, 32'(idx0 + 1), 32'd10);
      driveReq(1'b1, 3'b110, 32'(100 * (idx1 + 1)), 32'd1);
      #1;
      if (req_valid[0] && req_ready[0]) begin gl.push_back(2'd0); idx0++; end
      if (req_valid[1] && req_ready[1]) begin gl.push_back(2'd1); idx1++; end
    end
    req_valid = 2'b00;
    checkOutput("contention_done", (idx0 == 4 && idx1 == 4 && sb.size() == 0), 1);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("contention_grant%0d", k), (k < gl.size()) ? gl[k] : 2'b11, exp_g[k]);

    // Throughput: ten back-to-back requester 0 operations
    idx0 = 0;
    pushed = 0;
    hs = 0;
    first_acc = -1;
    last_hs = -1;
    for (int t = 0; t < 200 && hs < 10; t++) begin
      @(negedge clk);
      req_valid = {1'b0, idx0 < 10};
      driveReq(1'b0, 3'b010, 32'(idx0), 32'(2 * idx0));
      if (idx0 < 10 && pushed == idx0) begin
        sb.push_back('{2'b01, 32'(3 * idx0), idx0 == 0});
        pushed++;
      end
      #1;
      if (req_valid[0] && req_ready[0]) begin
        if (idx0 == 0) first_acc = cyc;
        idx0++;
      end
      if (rsp_valid[0] && rsp_ready[0]) begin
        hs++;
        last_hs = cyc;
      end
    end
    req_valid = 2'b00;
    checkOutput("tput_handshakes", hs, 10);
    checkOutput("tput_cycles", 64'(last_hs - first_acc + 1), 30);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
